ram8_scrub: RTL and testbench
=============================

Name: ram8_scrub

Overview:
- 8-entry x WIDTH-bit Hack-style register file (RAM8) with a built-in sequential scrub engine.
- A single load is fanned out to one of 8 registers through a 1-to-8 load decoder.
- Per-entry dirty flags are reduced by the existing or8way to a single any_dirty flag.
- Sits below RAM64 in the memory hierarchy; the scrub engine lets the CPU bring-up logic zero memory without issuing 8 explicit writes.

Parameters:
- WIDTH, 16, data word width in bits (Hack word).
- DEPTH, 8, number of entries; fixed at 8, because the address width and decoder are 8-way.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  write data.
- address  input  3  read/write entry select.
- load  input  1  write in into entry address at next rising edge.
- clear  input  1  request scrub of all 8 entries; sampled only when idle.
- out  output  WIDTH  contents of entry address (combinational read).
- busy  output  1  high while the scrub engine is active.
- dirty  output  8  bit i set when entry i has been loaded since last reset/scrub of i.
- any_dirty  output  1  OR of dirty[7:0].

Behaviour:
- Reset is synchronous and active-high, sampled on the clk rising edge. Reset values: all entries 0, dirty=8'h00, busy=0, state IDLE, scrub pointer 0.
- Consequences of reset: out=0 and any_dirty=0 after reset.
- Read: out = mem[address] combinationally, with zero-cycle latency. The read path is always available, including while busy.
- Write, state IDLE, load=1, clear=0: mem[address] <= in and dirty[address] <= 1 at the edge. out reflects the new value after the edge (Hack write-then-read semantics; no same-cycle bypass).
- Write with in=0 still sets dirty.
- FSM has 2 states, IDLE and SCRUB.
- IDLE -> SCRUB when clear=1 at an edge. ptr <= 0, busy <= 1.
- clear takes priority over load in the same cycle: that load is dropped, with no write and no dirty update.
- SCRUB: each edge, mem[ptr] <= 0, dirty[ptr] <= 0, ptr <= ptr+1.
- After the edge that zeroes entry 7, go to IDLE with busy <= 0 and ptr <= 0.
- busy is high for exactly 8 cycles.
- While in SCRUB, load and clear are ignored (no queuing). The host must wait for busy=0.
- Reset mid-scrub: immediate return to IDLE, busy=0, all entries 0, all dirty 0.
- Reset has priority over clear and load in the same cycle.
- Address wraps naturally (3 bits); there are no out-of-range cases.
- any_dirty is combinational from dirty via or8way instance.

Decomposition:
- Shared package ram8_pkg:
  - WORD_W=16, ADDR_W=3, DEPTH=8.
  - state enum {IDLE, SCRUB}.
- Sub-module dmux8way: 1-bit in, 3-bit sel, 8 one-hot outputs. It generates per-entry load enables for the write path; the scrub path uses the same decoder driven by ptr through a sel mux.
- Reuse the existing or8way for any_dirty.
- Target 150-250 lines of RTL.

Test Plan:
- Reset, then sweep address 0..7 with load=0 -> out=16'h0000 for every address, dirty=8'h00, any_dirty=0, busy=0.
- Write 16'h1234 @3, 16'hBEEF @7, 16'h0000 @0 on consecutive cycles, then read each -> out=1234/BEEF/0000; dirty=8'b10001001; any_dirty=1; entry 5 reads 0.
- Fill all entries with 16'hFFFF, pulse clear for 1 cycle -> busy=1 for exactly 8 cycles. Observe address 2 each cycle: it reads FFFF until the 3rd scrub edge, 0000 after. After busy falls, all entries are 0 and dirty=8'h00.
- clear=1 and load=1 (address 4, in=16'hAAAA) in the same cycle -> entry 4 reads 0 after scrub and dirty[4]=0. load=1 during busy (address 1, in=16'h5555) -> ignored, entry 1=0.
- Start a scrub on all-FFFF contents, assert reset after 4 busy cycles -> next edge busy=0 and entries 0..7 all 0. A clear one cycle after reset deasserts -> full 8-cycle scrub runs.
- Write 16'h00FF @6 only -> dirty=8'b01000000, any_dirty=1. Then clear -> any_dirty=0 once busy falls.

Source files
------------

// File: rtl/ram8_pkg.sv
// Shared constants and state type for the RAM8 register file with scrub engine.
package ram8_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    typedef enum logic {
        IDLE,
        SCRUB
    } state_t;

endpackage

// File: rtl/dmux8way.sv
// 1-to-8 demultiplexer: routes a single bit to the output selected by sel.
module dmux8way (
    input  logic       in,
    input  logic [2:0] sel,
    output logic [7:0] out
);

    // Only the selected output follows in; all others stay low.
    always_comb begin
        out      = 8'h00;
        out[sel] = in;
    end

endmodule

// File: rtl/or8way.sv
// 8-input OR reduction.
module or8way (
    input  logic [7:0] in,
    output logic       out
);

    assign out = |in;

endmodule

// File: rtl/ram8_scrub.sv
// 8-entry Hack-style register file with per-entry dirty flags and a
// sequential scrub engine that zeroes one entry per cycle.
module ram8_scrub
    import ram8_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] address,
    input  logic              load,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              busy,
    output logic [DEPTH-1:0]  dirty,
    output logic              any_dirty
);

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  ptr;
    logic [ADDR_W-1:0]  ptr_next;
    logic [WIDTH-1:0]   mem [DEPTH];

    logic               write_req;
    logic [ADDR_W-1:0]  write_sel;
    logic [WIDTH-1:0]   write_data;
    logic               set_dirty;
    logic [DEPTH-1:0]   write_en;

    // Next-state logic; the host write path and the scrub path share one
    // decoder, with the select steered to ptr while scrubbing.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        write_req  = 1'b0;
        write_sel  = address;
        write_data = in;
        set_dirty  = 1'b0;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_next = SCRUB;
                    ptr_next   = '0;
                end else if (load) begin
                    write_req = 1'b1;
                    set_dirty = 1'b1;
                end
            end
            SCRUB: begin
                write_req  = 1'b1;
                write_sel  = ptr;
                write_data = '0;
                ptr_next   = ptr + 3'd1;
                if (ptr == 3'd7) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    dmux8way u_load_dec (
        .in  (write_req),
        .sel (write_sel),
        .out (write_en)
    );

    // State register and scrub pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Storage and dirty flags; a scrub write clears the flag, a host write sets it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            dirty <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (write_en[i]) begin
                    mem[i]   <= write_data;
                    dirty[i] <= set_dirty;
                end
            end
        end
    end

    assign out  = mem[address];
    assign busy = (state == SCRUB);

    or8way u_any_dirty (
        .in  (dirty),
        .out (any_dirty)
    );

endmodule

// File: tb/tb_ram8_scrub.sv
// Scoreboard testbench for ram8_scrub: stimulus pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_ram8_scrub;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic [2:0]  address;
    logic        load;
    logic        clear;
    logic [15:0] out;
    logic        busy;
    logic [7:0]  dirty;
    logic        any_dirty;

    typedef struct packed {
        logic [15:0] exp_out;
        logic [7:0]  exp_dirty;
        logic        exp_busy;
        logic        exp_any;
    } exp_t;

    exp_t  expQ[$];
    string nameQ[$];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    ram8_scrub #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .address   (address),
        .load      (load),
        .clear     (clear),
        .out       (out),
        .busy      (busy),
        .dirty     (dirty),
        .any_dirty (any_dirty)
    );

    task automatic compareField(input string name, input string field,
                                input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s %s: got %h expected %h", name, field, got, exp);
        end
    endtask

    // Monitor: compare every pending expectation mid-cycle, away from the edge.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(negedge clk);
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                n = nameQ.pop_front();
                compareField(n, "out",       out,                e.exp_out);
                compareField(n, "dirty",     {8'h00, dirty},     {8'h00, e.exp_dirty});
                compareField(n, "busy",      {15'h0, busy},      {15'h0, e.exp_busy});
                compareField(n, "any_dirty", {15'h0, any_dirty}, {15'h0, e.exp_any});
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic ld, input logic cl,
                                 input logic [2:0] a, input logic [15:0] d);
        reset   = r;
        load    = ld;
        clear   = cl;
        address = a;
        in      = d;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] o,
                               input logic [7:0] d, input logic b);
        exp_t e;
        e.exp_out   = o;
        e.exp_dirty = d;
        e.exp_busy  = b;
        e.exp_any   = |d;
        expQ.push_back(e);
        nameQ.push_back(name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle: drive inputs, record what the outputs must show before the edge, advance.
    task automatic step(input string name, input logic r, input logic ld, input logic cl,
                        input logic [2:0] a, input logic [15:0] d,
                        input logic [15:0] o, input logic [7:0] dr, input logic b);
        applyStimulus(r, ld, cl, a, d);
        checkOutput(name, o, dr, b);
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] prior [8];
        logic [7:0]  expd;

        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
        tick();
        tick();

        $display("[TB] reset sweep");
        for (int a = 0; a < 8; a++)
            step($sformatf("rst_sweep%0d", a), 0, 0, 0, 3'(a), 16'h0, 16'h0000, 8'h00, 0);

        $display("[TB] directed writes");
        step("wr3",   0, 1, 0, 3'd3, 16'h1234, 16'h0000, 8'h00, 0);
        step("wr7",   0, 1, 0, 3'd7, 16'hBEEF, 16'h0000, 8'h08, 0);
        step("wr0",   0, 1, 0, 3'd0, 16'h0000, 16'h0000, 8'h88, 0);
        step("rd3",   0, 0, 0, 3'd3, 16'h0,    16'h1234, 8'h89, 0);
        step("rd7",   0, 0, 0, 3'd7, 16'h0,    16'hBEEF, 8'h89, 0);
        step("rd0",   0, 0, 0, 3'd0, 16'h0,    16'h0000, 8'h89, 0);
        step("rd5",   0, 0, 0, 3'd5, 16'h0,    16'h0000, 8'h89, 0);

        $display("[TB] fill and scrub");
        for (int a = 0; a < 8; a++) prior[a] = 16'h0000;
        prior[3] = 16'h1234;
        prior[7] = 16'hBEEF;
        expd = 8'h89;
        for (int a = 0; a < 8; a++) begin
            step($sformatf("fill%0d", a), 0, 1, 0, 3'(a), 16'hFFFF, prior[a], expd, 0);
            expd = expd | (8'h01 << a);
        end
        step("clr_pulse", 0, 0, 1, 3'd2, 16'h0, 16'hFFFF, 8'hFF, 0);
        for (int k = 0; k < 8; k++)
            step($sformatf("scrub_a2_k%0d", k), 0, 0, 0, 3'd2, 16'h0,
                 (k >= 3) ? 16'h0000 : 16'hFFFF, 8'hFF << k, 1);
        for (int a = 0; a < 8; a++)
            step($sformatf("post_scrub%0d", a), 0, 0, 0, 3'(a), 16'h0, 16'h0000, 8'h00, 0);

        $display("[TB] clear priority and busy ignores");
        step("clr_ld4", 0, 1, 1, 3'd4, 16'hAAAA, 16'h0000, 8'h00, 0);
        for (int k = 0; k < 8; k++) begin
            if (k == 2)
                step("busy_ld1", 0, 1, 0, 3'd1, 16'h5555, 16'h0000, 8'h00, 1);
            else if (k == 5)
                step("busy_clr", 0, 0, 1, 3'd4, 16'h0, 16'h0000, 8'h00, 1);
            else
                step($sformatf("prio_a4_k%0d", k), 0, 0, 0, 3'd4, 16'h0, 16'h0000, 8'h00, 1);
        end
        step("after_rd1", 0, 0, 0, 3'd1, 16'h0, 16'h0000, 8'h00, 0);
        step("after_rd4", 0, 0, 0, 3'd4, 16'h0, 16'h0000, 8'h00, 0);

        $display("[TB] reset mid-scrub");
        expd = 8'h00;
        for (int a = 0; a < 8; a++) begin
            step($sformatf("fill2_%0d", a), 0, 1, 0, 3'(a), 16'hFFFF, 16'h0000, expd, 0);
            expd = expd | (8'h01 << a);
        end
        step("clr2", 0, 0, 0, 3'd0, 16'h0, 16'hFFFF, 8'hFF, 0);
        step("clr2_go", 0, 0, 1, 3'd0, 16'h0, 16'hFFFF, 8'hFF, 0);
        for (int k = 0; k < 4; k++)
            step($sformatf("mid_a7_k%0d", k), 0, 0, 0, 3'd7, 16'h0, 16'hFFFF, 8'hFF << k, 1);
        step("mid_rst", 1, 1, 1, 3'd7, 16'h1111, 16'hFFFF, 8'hF0, 1);
        step("post_rst", 0, 0, 0, 3'd0, 16'h0, 16'h0000, 8'h00, 0);
        step("post_rst_clr", 0, 0, 1, 3'd1, 16'h0, 16'h0000, 8'h00, 0);
        for (int k = 0; k < 8; k++)
            step($sformatf("rescrub_a%0d", k), 0, 0, 0, 3'(k), 16'h0, 16'h0000, 8'h00, 1);
        step("rescrub_done", 0, 0, 0, 3'd0, 16'h0, 16'h0000, 8'h00, 0);

        $display("[TB] single dirty then clear");
        step("wr6",    0, 1, 0, 3'd6, 16'h00FF, 16'h0000, 8'h00, 0);
        step("rd6",    0, 0, 0, 3'd6, 16'h0,    16'h00FF, 8'h40, 0);
        step("clr6",   0, 0, 1, 3'd6, 16'h0,    16'h00FF, 8'h40, 0);
        for (int k = 0; k < 8; k++)
            step($sformatf("scrub_a6_k%0d", k), 0, 0, 0, 3'd6, 16'h0,
                 (k == 7) ? 16'h0000 : 16'h00FF, (k == 7) ? 8'h00 : 8'h40, 1);
        step("final6", 0, 0, 0, 3'd6, 16'h0, 16'h0000, 8'h00, 0);

        @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
